// File: rtl/mdu_wb_fifo.sv
// MDU writeback result buffer: holds completed MDU results
// until the CDB arbiter takes them, in strict completion order.
package mdu_wb_pkg;

  typedef struct packed {
    logic       valid;
    logic [3:0] cause;
  } exc_info_t;

  typedef struct packed {
    exc_info_t exc_info;
  } ctrl_t;

  typedef struct packed {
    logic       is_ld;
    logic       is_st;
    logic [1:0] size;
  } lsu_info_t;

  typedef struct packed {
    logic [31:0] w_data;
    logic [5:0]  rob_id;
    logic [4:0]  w_reg;
    logic        r_valid;
    lsu_info_t   lsu_info;
    ctrl_t       ctrl;
  } cdb_info_t;

  localparam int unsigned CDB_W = $bits(cdb_info_t);

endpackage

module mdu_wb_fifo
  import mdu_wb_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned PTR_LEN = $clog2(DEPTH),
  parameter int unsigned CNT_LEN = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid_i,
  input  logic [CDB_W-1:0]   in_result_i,
  output logic               fifo_ready_o,
  output logic               out_valid_o,
  output logic [CDB_W-1:0]   out_result_o,
  input  logic               out_ready_i,
  output logic [CNT_LEN-1:0] count_o
);

  localparam logic [CNT_LEN-1:0] FULL = CNT_LEN'(DEPTH);

  logic [CDB_W-1:0]   mem_q [DEPTH];
  logic [PTR_LEN-1:0] head_q, head_d;
  logic [PTR_LEN-1:0] tail_q, tail_d;
  logic [CNT_LEN-1:0] count_q, count_d;
  logic               ready_q, ready_d;
  logic               push, pop, wr_en;

  assign out_valid_o  = (count_q != '0);
  assign push         = in_valid_i & ready_q;
  assign pop          = out_valid_o & out_ready_i;
  assign wr_en        = push & ~flush & ~rst;
  assign fifo_ready_o = ready_q;
  assign count_o      = count_q;
  assign out_result_o = out_valid_o ? mem_q[head_q] : '0;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    ready_d = ready_q;
    // A flush drops everything, including this cycle's handshakes
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      ready_d = 1'b1;
    end else begin
      if (push) tail_d = tail_q + PTR_LEN'(1);
      if (pop)  head_d = head_q + PTR_LEN'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_LEN'(1);
        2'b01:   count_d = count_q - CNT_LEN'(1);
        default: count_d = count_q;
      endcase
      ready_d = (count_d < FULL);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ready_q <= 1'b1;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ready_q <= ready_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[tail_q] <= in_result_i;
  end

endmodule

// File: tb/tb_mdu_wb_fifo.sv
// Directed bench for mdu_wb_fifo: reset, pass-through, full,
// wrap-around, concurrent push/pop and flush.
module tb_mdu_wb_fifo;
  import mdu_wb_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic            in_valid_i;
  cdb_info_t       in_result_i;
  logic            fifo_ready_o;
  logic            out_valid_o;
  logic [CDB_W-1:0] out_result_o;
  logic            out_ready_i;
  logic [2:0]      count_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mdu_wb_fifo #(.DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid_i   (in_valid_i),
    .in_result_i  (in_result_i),
    .fifo_ready_o (fifo_ready_o),
    .out_valid_o  (out_valid_o),
    .out_result_o (out_result_o),
    .out_ready_i  (out_ready_i),
    .count_o      (count_o)
  );

  function automatic cdb_info_t mk(input int rob, input logic [31:0] d);
    cdb_info_t r;
    r.w_data                = d;
    r.rob_id                = 6'(rob);
    r.w_reg                 = 5'(rob) ^ 5'h1f;
    r.r_valid               = ~r.rob_id[0];
    r.lsu_info.is_ld        = r.rob_id[1];
    r.lsu_info.is_st        = r.rob_id[2];
    r.lsu_info.size         = r.rob_id[1:0];
    r.ctrl.exc_info.valid   = r.rob_id[0];
    r.ctrl.exc_info.cause   = r.rob_id[3:0] ^ 4'ha;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    cdb_info_t q[$];
    int sent, recv, cyc;
    logic tog;

    rst = 1'b1; flush = 1'b0; in_valid_i = 1'b0;
    in_result_i = '0; out_ready_i = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_ready", 64'(fifo_ready_o), 64'd1);
    chk("rst_valid", 64'(out_valid_o), 64'd0);
    chk("rst_result", 64'(out_result_o), 64'd0);
    chk("rst_count", 64'(count_o), 64'd0);

    // single pass-through
    in_valid_i = 1'b1; in_result_i = mk(5, 32'h1234); out_ready_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
    chk("pt_valid", 64'(out_valid_o), 64'd1);
    chk("pt_result", 64'(out_result_o), 64'(mk(5, 32'h1234)));
    chk("pt_count1", 64'(count_o), 64'd1);
    tick();
    chk("pt_count0", 64'(count_o), 64'd0);
    chk("pt_valid0", 64'(out_valid_o), 64'd0);
    chk("pt_result0", 64'(out_result_o), 64'd0);

    // fill to full
    out_ready_i = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      in_valid_i = 1'b1; in_result_i = mk(i, 32'h100 + 32'(i));
      tick();
      if (i == 3) chk("fill_ready3", 64'(fifo_ready_o), 64'd1);
    end
    chk("full_count", 64'(count_o), 64'd4);
    chk("full_ready", 64'(fifo_ready_o), 64'd0);
    in_result_i = mk(9, 32'h999);
    tick();
    in_valid_i = 1'b0;
    chk("full_drop_cnt", 64'(count_o), 64'd4);
    chk("full_stable", 64'(out_result_o), 64'(mk(1, 32'h101)));
    out_ready_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_order", 64'(out_result_o), 64'(mk(i, 32'h100 + 32'(i))));
      tick();
      if (i == 1) chk("drain_ready", 64'(fifo_ready_o), 64'd1);
    end
    chk("drain_count", 64'(count_o), 64'd0);
    out_ready_i = 1'b0;

    // wrap-around with toggling out_ready
    sent = 0; recv = 0; cyc = 0; tog = 1'b1;
    while ((recv < 10) && (cyc < 200)) begin
      in_valid_i  = (sent < 10);
      in_result_i = mk(sent, 32'hA000 + 32'(sent));
      out_ready_i = tog;
      if (out_valid_o && out_ready_i) begin
        if (q.size() == 0) begin
          chk("wrap_dup", 64'(out_result_o), 64'hdead);
        end else begin
          chk("wrap_data", 64'(out_result_o), 64'(q.pop_front()));
        end
        recv++;
      end
      if (in_valid_i && fifo_ready_o) begin
        q.push_back(in_result_i);
        sent++;
      end
      tick();
      if (count_o > 3'd4) chk("wrap_cnt_max", 64'(count_o), 64'd4);
      tog = ~tog;
      cyc++;
    end
    in_valid_i = 1'b0; out_ready_i = 1'b0;
    chk("wrap_recv", 64'(recv), 64'd10);
    chk("wrap_empty", 64'(count_o), 64'd0);

    // concurrent push/pop at count 2
    in_valid_i = 1'b1; in_result_i = mk(20, 32'h20); tick();
    in_result_i = mk(21, 32'h21); tick();
    chk("cc_count2", 64'(count_o), 64'd2);
    in_result_i = mk(7, 32'h7777); out_ready_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
    chk("cc_count", 64'(count_o), 64'd2);
    chk("cc_head", 64'(out_result_o), 64'(mk(21, 32'h21)));
    tick();
    chk("cc_new", 64'(out_result_o), 64'(mk(7, 32'h7777)));
    chk("cc_count1", 64'(count_o), 64'd1);
    tick();
    out_ready_i = 1'b0;
    chk("cc_count0", 64'(count_o), 64'd0);

    // flush with 3 entries and a push in the same cycle
    for (int i = 30; i < 33; i++) begin
      in_valid_i = 1'b1; in_result_i = mk(i, 32'(i)); tick();
    end
    chk("fl_count3", 64'(count_o), 64'd3);
    flush = 1'b1; in_result_i = mk(33, 32'd33); out_ready_i = 1'b1;
    tick();
    flush = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
    chk("fl_count", 64'(count_o), 64'd0);
    chk("fl_valid", 64'(out_valid_o), 64'd0);
    chk("fl_ready", 64'(fifo_ready_o), 64'd1);
    chk("fl_result", 64'(out_result_o), 64'd0);
    in_valid_i = 1'b1; in_result_i = mk(11, 32'hB0B); tick();
    in_valid_i = 1'b0;
    chk("fl_next", 64'(out_result_o), 64'(mk(11, 32'hB0B)));
    chk("fl_next_cnt", 64'(count_o), 64'd1);

    // reset mid-stream wins over flush
    rst = 1'b1; flush = 1'b1; tick();
    rst = 1'b0; flush = 1'b0;
    chk("mid_rst_cnt", 64'(count_o), 64'd0);
    chk("mid_rst_ready", 64'(fifo_ready_o), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
